// File: rtl/add_pkg.sv
// Shared definitions for the pipelined ADD unit: operation encodings.
package add_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_ADC = 2'd2,
        OP_SBB = 2'd3
    } op_e;

endpackage

// File: rtl/add_slice.sv
// Combinational SEG-bit adder slice: sum, carry-out and carry into the slice MSB.
module add_slice #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co,
    output logic           cmsb
);

    logic [SEG:0] full;

    always_comb begin
        full = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, ci};
        s    = full[SEG-1:0];
        co   = full[SEG];
        // Carry into the MSB recovered from the MSB sum bit and its operands.
        cmsb = full[SEG-1] ^ a[SEG-1] ^ b[SEG-1];
    end

endmodule

// File: rtl/add_pipe.sv
// Pipelined ADD/SUB/ADC/SBB unit: one SEG-bit slice per stage, carry registered
// between stages, valid/ready handshake with a single global advance enable.
module add_pipe #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             cin,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic [TAG_W-1:0] tag_out
);

    import add_pkg::*;

    localparam int unsigned STAGES = WIDTH / SEG;
    localparam int unsigned NPR    = (STAGES > 1) ? STAGES - 1 : 1;
    localparam int unsigned L      = STAGES - 1;

    if (WIDTH % SEG != 0) begin : g_bad_seg
        $fatal(1, "add_pipe: WIDTH must be a multiple of SEG");
    end

    logic             en;
    logic [WIDTH-1:0] bp;
    logic             c0;

    // Per-stage combinational inputs and results
    logic [WIDTH-1:0] ain   [STAGES];
    logic [WIDTH-1:0] bin   [STAGES];
    logic [WIDTH-1:0] sin   [STAGES];
    logic [WIDTH-1:0] sout  [STAGES];
    logic [SEG-1:0]   slc_s [STAGES];
    logic             cin_s [STAGES];
    logic             cout  [STAGES];
    logic             cmsb  [STAGES];
    logic             vin   [STAGES];
    logic [TAG_W-1:0] tin   [STAGES];

    // Inter-stage registers (stage 0 .. STAGES-2)
    logic [WIDTH-1:0] a_q [NPR];
    logic [WIDTH-1:0] b_q [NPR];
    logic [WIDTH-1:0] s_q [NPR];
    logic             c_q [NPR];
    logic             v_q [NPR];
    logic [TAG_W-1:0] t_q [NPR];

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    always_comb begin
        bp = b;
        c0 = 1'b0;
        case (op_e'(op))
            OP_ADD: begin bp = b;  c0 = 1'b0; end
            OP_SUB: begin bp = ~b; c0 = 1'b1; end
            OP_ADC: begin bp = b;  c0 = cin;  end
            OP_SBB: begin bp = ~b; c0 = cin;  end
            default: begin bp = b; c0 = 1'b0; end
        endcase
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign ain[k]   = a;
            assign bin[k]   = bp;
            assign cin_s[k] = c0;
            assign sin[k]   = '0;
            assign vin[k]   = in_valid;
            assign tin[k]   = tag_in;
        end else begin : g_next
            assign ain[k]   = a_q[k-1];
            assign bin[k]   = b_q[k-1];
            assign cin_s[k] = c_q[k-1];
            assign sin[k]   = s_q[k-1];
            assign vin[k]   = v_q[k-1];
            assign tin[k]   = t_q[k-1];
        end

        add_slice #(.SEG(SEG)) u_slice (
            .a    (ain[k][k*SEG +: SEG]),
            .b    (bin[k][k*SEG +: SEG]),
            .ci   (cin_s[k]),
            .s    (slc_s[k]),
            .co   (cout[k]),
            .cmsb (cmsb[k])
        );

        // Slices above k are still zero in the accumulated sum, so OR-in is exact.
        assign sout[k] = sin[k] | (WIDTH'(slc_s[k]) << (k * SEG));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NPR; i++) begin
                v_q[i] <= 1'b0;
                a_q[i] <= '0;
                b_q[i] <= '0;
                s_q[i] <= '0;
                c_q[i] <= 1'b0;
                t_q[i] <= '0;
            end
        end else if (en) begin
            for (int unsigned i = 0; i + 1 < STAGES; i++) begin
                v_q[i] <= vin[i];
                a_q[i] <= ain[i];
                b_q[i] <= bin[i];
                s_q[i] <= sout[i];
                c_q[i] <= cout[i];
                t_q[i] <= tin[i];
            end
        end
    end

    // Result registers only load on a valid op so bubbles leave them untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
            tag_out   <= '0;
        end else if (en) begin
            out_valid <= vin[L];
            if (vin[L]) begin
                sum      <= sout[L];
                carry    <= cout[L];
                overflow <= cout[L] ^ cmsb[L];
                zero     <= (sout[L] == '0);
                negative <= sout[L][WIDTH-1];
                tag_out  <= tin[L];
            end
        end
    end

endmodule

// File: tb/tb_add_pipe.sv
// Self-checking bench for add_pipe: directed corner cases, flow control, reset, and
// randomized traffic checked against an integer-arithmetic reference model.
module tb_add_pipe;

    localparam int W      = 16;
    localparam int S      = 4;
    localparam int T      = 4;
    localparam int STAGES = W / S;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic [1:0]   op;
    logic         cin;
    logic [T-1:0] tag_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry, overflow, zero, negative;
    logic [T-1:0] tag_out;

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;
    bit rnd_mode = 1'b0;

    typedef struct {
        logic [W-1:0] s;
        logic         c, v, z, n;
        logic [T-1:0] t;
    } exp_t;

    exp_t q[$];

    add_pipe #(.WIDTH(W), .SEG(S), .TAG_W(T)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .cin(cin), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .carry(carry),
        .overflow(overflow), .zero(zero), .negative(negative), .tag_out(tag_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: true integer results, carry from the unsigned value, overflow from range.
    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c, input logic [T-1:0] tg);
        longint ux, uy, sx, sy, ures, sres, m;
        exp_t e;
        m  = longint'(1) << W;
        ux = longint'(x);
        uy = longint'(y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'd0:    begin ures = ux + uy;                 sres = sx + sy;               end
            2'd1:    begin ures = ux - uy + m;             sres = sx - sy;               end
            2'd2:    begin ures = ux + uy + longint'(c);   sres = sx + sy + longint'(c); end
            default: begin ures = ux - uy + m - 1 + longint'(c); sres = sx - sy - 1 + longint'(c); end
        endcase
        e.s = W'(ures % m);
        e.c = (ures >= m);
        e.v = (sres < -(m / 2)) || (sres > (m / 2) - 1);
        e.z = (e.s == '0);
        e.n = e.s[W-1];
        e.t = tg;
        return e;
    endfunction

    // Scoreboard and hold-stability monitor, sampled mid-cycle.
    logic [31:0] snap;
    bit          held = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q.delete();
            held = 1'b0;
        end else begin
            if (held)
                check("hold_stable", {tag_out, carry, overflow, zero, negative, sum}, snap);
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_out", out_valid, 1'b0);
                end else if (out_ready) begin
                    e = q.pop_front();
                    check("sb_sum", sum, e.s);
                    check("sb_flags", {carry, overflow, zero, negative}, {e.c, e.v, e.z, e.n});
                    check("sb_tag", tag_out, e.t);
                    n_out++;
                end
            end
            held = out_valid && !out_ready;
            snap = {8'h00, tag_out, carry, overflow, zero, negative, sum};
            if (in_valid && in_ready)
                q.push_back(model(op, a, b, cin, tag_in));
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_mode) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Present one op and hold it until accepted; returns just after the accepting edge.
    task automatic send(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c, input logic [T-1:0] tg);
        bit acc;
        int n;
        op = o; a = x; b = y; cin = c; tag_in = tg; in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic directed(input string nm, input logic [1:0] o, input logic [W-1:0] x,
                            input logic [W-1:0] y, input logic c, input logic [W-1:0] es,
                            input logic ec, input logic ev, input logic ez, input logic en_);
        int lat;
        out_ready = 1'b1;
        send(o, x, y, c, 4'hA);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({nm, "_lat"}, lat, STAGES);
        check({nm, "_sum"}, sum, es);
        check({nm, "_flags"}, {carry, overflow, zero, negative}, {ec, ev, ez, en_});
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string nm);
        int n;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(nm, q.size(), 0);
    endtask

    initial begin
        int          first, exp_tag, base;
        logic [31:0] frozen;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = '0; cin = 1'b0; tag_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", {out_valid, tag_out, carry, overflow, zero, negative, sum}, 0);
        rst_n = 1'b1;
        check("reset_in_ready", in_ready, 1'b1);

        directed("add_ovf",   2'd0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
        directed("add_wrap",  2'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        directed("sub_borrow",2'd1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
        directed("sub_ovf",   2'd1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
        directed("adc",       2'd2, 16'h1234, 16'h0001, 1'b1, 16'h1236, 1'b0, 1'b0, 1'b0, 1'b0);
        directed("sbb",       2'd3, 16'h0010, 16'h0001, 1'b0, 16'h000E, 1'b1, 1'b0, 1'b0, 1'b0);

        // Back-to-back: 8 ops, results on 8 consecutive cycles.
        out_ready = 1'b1;
        exp_tag = 0;
        first = -1;
        for (int t = 0; t < 8 + STAGES + 4; t++) begin
            if (t < 8) begin
                op = 2'($urandom_range(0, 3)); a = W'($urandom); b = W'($urandom);
                cin = 1'($urandom); tag_in = T'(t); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (t < 8) check("b2b_in_ready", in_ready, 1'b1);
            if (out_valid) begin
                if (first < 0) first = t;
                check("b2b_tag", tag_out, exp_tag);
                check("b2b_slot", t - first, exp_tag);
                exp_tag++;
            end
            @(posedge clk);
            #1;
        end
        check("b2b_count", exp_tag, 8);
        check("b2b_first", first, STAGES);

        // Stall with the pipe full.
        out_ready = 1'b0;
        base = n_out;
        for (int i = 0; i < STAGES; i++)
            send(2'($urandom_range(0, 3)), W'($urandom), W'($urandom), 1'($urandom), T'(8 + i));
        check("stall_full", out_valid, 1'b1);
        frozen = {8'h00, tag_out, carry, overflow, zero, negative, sum};
        op = 2'd0; a = 16'h0101; b = 16'h0202; cin = 1'b0; tag_in = T'(12); in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall_in_ready", in_ready, 1'b0);
            check("stall_tag", tag_out, 8);
            check("stall_frozen", {tag_out, carry, overflow, zero, negative, sum}, frozen);
        end
        out_ready = 1'b1;
        send(2'd0, 16'h0101, 16'h0202, 1'b0, T'(12));
        wait_drain("stall_drain");
        check("stall_count", n_out - base, STAGES + 1);

        // Reset with 3 ops in flight.
        for (int i = 0; i < 3; i++)
            send(2'($urandom_range(0, 3)), W'($urandom), W'($urandom), 1'($urandom), T'(i));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_outs", {out_valid, tag_out, carry, overflow, zero, negative, sum}, 0);
        check("midrst_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check("midrst_stale", out_valid, 1'b0);
        end
        directed("post_rst", 2'd0, 16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic with random backpressure.
        rnd_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) != 0)
                send(2'($urandom_range(0, 3)), W'($urandom), W'($urandom), 1'($urandom), T'($urandom));
            else begin
                @(posedge clk);
                #1;
            end
        end
        rnd_mode = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain("rand_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
